// File: rtl/rsa_pkg.sv
// Shared encodings for the modular-exponentiation sequencer.
package rsa_pkg;

   // FSM states
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LOAD   = 3'd1;
   localparam logic [2:0] ST_TO_P   = 3'd2;
   localparam logic [2:0] ST_TO_ONE = 3'd3;
   localparam logic [2:0] ST_SQR    = 3'd4;
   localparam logic [2:0] ST_MUL    = 3'd5;
   localparam logic [2:0] ST_FROM   = 3'd6;
   localparam logic [2:0] ST_DONE   = 3'd7;

   // Multiply-op phases
   localparam logic PH_ISSUE = 1'b0;
   localparam logic PH_WAIT  = 1'b1;

   // Operand-select codes
   localparam logic [2:0] SEL_ZERO  = 3'd0;
   localparam logic [2:0] SEL_P     = 3'd1;
   localparam logic [2:0] SEL_CONST = 3'd2;
   localparam logic [2:0] SEL_ONE   = 3'd3;
   localparam logic [2:0] SEL_ACC   = 3'd4;
   localparam logic [2:0] SEL_PM    = 3'd5;

   // True for the states that own a multiplier operation.
   function automatic logic is_op_state(input logic [2:0] state);
      return (state == ST_TO_P) || (state == ST_TO_ONE) || (state == ST_SQR) ||
             (state == ST_MUL)  || (state == ST_FROM);
   endfunction

endpackage

// File: rtl/rsa_operand_mux.sv
// Maps sequencer state/phase onto multiplier operands and the issue strobe.
// Operands are purely a function of state and latched registers, so they
// stay stable for the whole WAIT phase without extra holding registers.
module rsa_operand_mux
   import rsa_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [2:0]       i_state,
   input  logic             i_phase,
   input  logic [WIDTH-1:0] i_p,
   input  logic [WIDTH-1:0] i_const,
   input  logic [WIDTH-1:0] i_acc,
   input  logic [WIDTH-1:0] i_pm,
   output logic             o_mm_start,
   output logic [WIDTH-1:0] o_mm_a,
   output logic [WIDTH-1:0] o_mm_b
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [2:0] w_sel_a;
   logic [2:0] w_sel_b;

   function automatic logic [WIDTH-1:0] f_pick(input logic [2:0]       sel,
                                               input logic [WIDTH-1:0] p,
                                               input logic [WIDTH-1:0] k,
                                               input logic [WIDTH-1:0] acc,
                                               input logic [WIDTH-1:0] pm);
      case (sel)
         SEL_P:     return p;
         SEL_CONST: return k;
         SEL_ONE:   return ONE;
         SEL_ACC:   return acc;
         SEL_PM:    return pm;
         default:   return '0;
      endcase
   endfunction

   // Operand selection per op state; outside op states both operands read zero.
   always_comb begin
      w_sel_a = SEL_ZERO;
      w_sel_b = SEL_ZERO;
      case (i_state)
         ST_TO_P:   begin w_sel_a = SEL_P;   w_sel_b = SEL_CONST; end
         ST_TO_ONE: begin w_sel_a = SEL_ONE; w_sel_b = SEL_CONST; end
         ST_SQR:    begin w_sel_a = SEL_ACC; w_sel_b = SEL_ACC;   end
         ST_MUL:    begin w_sel_a = SEL_ACC; w_sel_b = SEL_PM;    end
         ST_FROM:   begin w_sel_a = SEL_ACC; w_sel_b = SEL_ONE;   end
         default:   begin w_sel_a = SEL_ZERO; w_sel_b = SEL_ZERO; end
      endcase
   end

   assign o_mm_a     = f_pick(w_sel_a, i_p, i_const, i_acc, i_pm);
   assign o_mm_b     = f_pick(w_sel_b, i_p, i_const, i_acc, i_pm);
   assign o_mm_start = is_op_state(i_state) && (i_phase == PH_ISSUE);

endmodule

// File: rtl/rsa_modexp_sequencer.sv
// Left-to-right square-and-multiply sequencer driving an external
// Montgomery multiplier: C = P^E mod M.
//
//  state  | meaning
//  IDLE   | waiting for a start rising edge
//  LOAD   | operands latched; reject even modulus
//  TO_P   | Pm = MontMul(p, R^2)
//  TO_ONE | A  = MontMul(1, R^2) = R mod M
//  SQR    | A  = MontMul(A, A) for current exponent bit
//  MUL    | A  = MontMul(A, Pm) when exponent bit is set
//  FROM   | A  = MontMul(A, 1), leaving Montgomery form
//  DONE   | publish result, pulse done, raise irq
module rsa_modexp_sequencer
   import rsa_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_stop,
   input  logic [WIDTH-1:0] i_p_in,
   input  logic [WIDTH-1:0] i_e_in,
   input  logic [WIDTH-1:0] i_m_in,
   input  logic [WIDTH-1:0] i_const_in,
   output logic             o_mm_start,
   output logic [WIDTH-1:0] o_mm_a,
   output logic [WIDTH-1:0] o_mm_b,
   output logic [WIDTH-1:0] o_mm_m,
   input  logic             i_mm_done,
   input  logic [WIDTH-1:0] i_mm_result,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_irq,
   output logic             o_err,
   output logic [WIDTH-1:0] o_c_out
);

   localparam int             CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]  CNT_TOP = CW'(WIDTH - 1);

   logic [2:0]       r_state;
   logic             r_phase;
   logic             r_start_q;
   logic [WIDTH-1:0] r_p, r_e, r_m, r_const;
   logic [WIDTH-1:0] r_pm, r_acc, r_c;
   logic [CW-1:0]    r_cnt;
   logic             r_busy, r_done, r_irq, r_err;

   logic             w_launch;
   logic             w_bit;
   logic             w_cnt_zero;

   assign w_launch   = i_start && !r_start_q && !i_stop;
   assign w_bit      = r_e[r_cnt];
   assign w_cnt_zero = (r_cnt == '0);

   // Sequencer FSM, exponent bit counter and operand/result registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= ST_IDLE;
         r_phase   <= PH_ISSUE;
         r_start_q <= 1'b0;
         r_p       <= '0;
         r_e       <= '0;
         r_m       <= '0;
         r_const   <= '0;
         r_pm      <= '0;
         r_acc     <= '0;
         r_c       <= '0;
         r_cnt     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_irq     <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_start_q <= i_start;
         r_done    <= 1'b0;
         if ((r_state != ST_IDLE) && i_stop) begin
            // Abort beats everything, including a coincident mm_done.
            r_state <= ST_IDLE;
            r_phase <= PH_ISSUE;
            r_busy  <= 1'b0;
            r_irq   <= 1'b0;
            r_err   <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_launch) begin
                     r_p     <= i_p_in;
                     r_e     <= i_e_in;
                     r_m     <= i_m_in;
                     r_const <= i_const_in;
                     r_irq   <= 1'b0;
                     r_err   <= 1'b0;
                     r_busy  <= 1'b1;
                     r_state <= ST_LOAD;
                  end
               end
               ST_LOAD: begin
                  if (!r_m[0]) begin
                     r_err   <= 1'b1;
                     r_done  <= 1'b1;
                     r_busy  <= 1'b0;
                     r_state <= ST_IDLE;
                  end else begin
                     r_phase <= PH_ISSUE;
                     r_state <= ST_TO_P;
                  end
               end
               ST_DONE: begin
                  r_c     <= r_acc;
                  r_done  <= 1'b1;
                  r_irq   <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
               default: begin
                  if (r_phase == PH_ISSUE) begin
                     r_phase <= PH_WAIT;
                  end else if (i_mm_done) begin
                     r_phase <= PH_ISSUE;
                     case (r_state)
                        ST_TO_P: begin
                           r_pm    <= i_mm_result;
                           r_state <= ST_TO_ONE;
                        end
                        ST_TO_ONE: begin
                           r_acc   <= i_mm_result;
                           r_cnt   <= CNT_TOP;
                           r_state <= (r_e == '0) ? ST_FROM : ST_SQR;
                        end
                        ST_SQR: begin
                           r_acc <= i_mm_result;
                           if (w_bit) begin
                              r_state <= ST_MUL;
                           end else if (w_cnt_zero) begin
                              r_state <= ST_FROM;
                           end else begin
                              r_cnt <= r_cnt - 1'b1;
                           end
                        end
                        ST_MUL: begin
                           r_acc <= i_mm_result;
                           if (w_cnt_zero) begin
                              r_state <= ST_FROM;
                           end else begin
                              r_cnt   <= r_cnt - 1'b1;
                              r_state <= ST_SQR;
                           end
                        end
                        default: begin
                           r_acc   <= i_mm_result;
                           r_state <= ST_DONE;
                        end
                     endcase
                  end
               end
            endcase
         end
      end
   end

   rsa_operand_mux #(.WIDTH(WIDTH)) u_operand_mux (
      .i_state    (r_state),
      .i_phase    (r_phase),
      .i_p        (r_p),
      .i_const    (r_const),
      .i_acc      (r_acc),
      .i_pm       (r_pm),
      .o_mm_start (o_mm_start),
      .o_mm_a     (o_mm_a),
      .o_mm_b     (o_mm_b)
   );

   assign o_mm_m  = r_m;
   assign o_busy  = r_busy;
   assign o_done  = r_done;
   assign o_irq   = r_irq;
   assign o_err   = r_err;
   assign o_c_out = r_c;

endmodule

// File: tb/tb_rsa_modexp_sequencer.sv
// Bench for rsa_modexp_sequencer with a 10-cycle Montgomery multiplier model.
module tb_rsa_modexp_sequencer;

   localparam int LAT = 10;

   logic       clk = 1'b0;
   logic       rst, start, stop;
   logic [7:0] p_in, e_in, m_in, const_in;
   logic       mm_start, mm_done;
   logic [7:0] mm_a, mm_b, mm_m, mm_result;
   logic       busy, done, irq, err;
   logic [7:0] c_out;

   int n_checks = 0;
   int n_errors = 0;
   int n_mm     = 0;
   int n_done   = 0;
   int base_mm, base_done, cyc_wait;

   logic [7:0] q_a[$];
   logic [7:0] q_b[$];
   logic [7:0] exp_c, exp_m, pend_c;
   logic       exp_irq, exp_err, pend_err;
   logic       hold_valid;
   logic [7:0] hold_a, hold_b;

   logic       mul_pend;
   int         mul_cnt;
   logic [7:0] mul_res;

   always #5 clk = ~clk;

   rsa_modexp_sequencer #(.WIDTH(8)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_start     (start),
      .i_stop      (stop),
      .i_p_in      (p_in),
      .i_e_in      (e_in),
      .i_m_in      (m_in),
      .i_const_in  (const_in),
      .o_mm_start  (mm_start),
      .o_mm_a      (mm_a),
      .o_mm_b      (mm_b),
      .o_mm_m      (mm_m),
      .i_mm_done   (mm_done),
      .i_mm_result (mm_result),
      .o_busy      (busy),
      .o_done      (done),
      .o_irq       (irq),
      .o_err       (err),
      .o_c_out     (c_out)
   );

   // a*b*R^-1 mod m found by search: the r in [0,m) with r*256 == a*b (mod m).
   function automatic logic [7:0] mont(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m);
      int ab;
      int res;
      ab  = (int'(a) * int'(b)) % int'(m);
      res = 0;
      for (int r = int'(m) - 1; r >= 0; r--)
         if (((r * 256) % int'(m)) == ab) res = r;
      return 8'(res);
   endfunction

   function automatic int pow_mod(input int p, input int e, input int m);
      int acc;
      acc = 1 % m;
      for (int i = 0; i < e; i++) acc = (acc * p) % m;
      return acc;
   endfunction

   task automatic chk(input string name, input int act, input int expv);
      n_checks++;
      if (act != expv) begin
         n_errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
      end
   endtask

   // Expected operand stream for one operation, plus the expected result.
   task automatic build_ops(input logic [7:0] p, input logic [7:0] e, input logic [7:0] m, input logic [7:0] k);
      logic [7:0] pm, a;
      q_a.delete();
      q_b.delete();
      pend_err = !m[0];
      if (m[0]) begin
         q_a.push_back(p);    q_b.push_back(k);
         pm = mont(p, k, m);
         q_a.push_back(8'd1); q_b.push_back(k);
         a = mont(8'd1, k, m);
         if (e != 8'd0) begin
            for (int i = 7; i >= 0; i--) begin
               q_a.push_back(a); q_b.push_back(a);
               a = mont(a, a, m);
               if (e[i]) begin
                  q_a.push_back(a); q_b.push_back(pm);
                  a = mont(a, pm, m);
               end
            end
         end
         q_a.push_back(a); q_b.push_back(8'd1);
         pend_c = 8'(pow_mod(int'(p), int'(e), int'(m)));
      end
   endtask

   task automatic launch(input logic [7:0] p, input logic [7:0] e, input logic [7:0] m,
                         input logic [7:0] k, input bit hold);
      @(negedge clk);
      p_in = p; e_in = e; m_in = m; const_in = k;
      build_ops(p, e, m, k);
      exp_m = m;
      start = 1'b1;
      @(posedge clk);
      #1;
      exp_irq = 1'b0;
      exp_err = 1'b0;
      if (!hold) start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string name, output int cycles);
      int start_n;
      int k;
      start_n = n_done;
      k = 0;
      while (n_done == start_n && k < budget) begin
         @(posedge clk);
         k++;
      end
      chk({name, "_done_seen"}, int'(n_done != start_n), 1);
      cycles = k;
      @(negedge clk);
   endtask

   // Multiplier model: result appears LAT cycles after the issue cycle.
   initial begin
      mm_done = 1'b0; mm_result = 8'd0; mul_pend = 1'b0; mul_cnt = 0; mul_res = 8'd0;
      forever begin
         @(posedge clk);
         #1;
         mm_done = 1'b0;
         if (rst) begin
            mul_pend = 1'b0;
         end else begin
            if (mul_pend) begin
               mul_cnt--;
               if (mul_cnt == 0) begin
                  mm_done   = 1'b1;
                  mm_result = mul_res;
                  mul_pend  = 1'b0;
               end
            end
            if (mm_start) begin
               mul_pend = 1'b1;
               mul_cnt  = LAT;
               mul_res  = mont(mm_a, mm_b, mm_m);
            end
         end
      end
   end

   // Compare process: operand stream, operand stability, status while idle.
   always @(negedge clk) begin
      if (rst) begin
         hold_valid = 1'b0;
      end else begin
         if (mm_start) begin
            n_mm++;
            chk("mm_start_expected", int'(q_a.size() > 0), 1);
            if (q_a.size() > 0) begin
               chk("mm_a", int'(mm_a), int'(q_a.pop_front()));
               chk("mm_b", int'(mm_b), int'(q_b.pop_front()));
               chk("mm_m", int'(mm_m), int'(exp_m));
            end
            hold_valid = 1'b1;
            hold_a = mm_a;
            hold_b = mm_b;
         end else if (hold_valid && busy) begin
            chk("mm_a_hold", int'(mm_a), int'(hold_a));
            chk("mm_b_hold", int'(mm_b), int'(hold_b));
         end
         if (mm_done || !busy) hold_valid = 1'b0;
         if (done) begin
            n_done++;
            if (pend_err) exp_err = 1'b1;
            else begin
               exp_c   = pend_c;
               exp_irq = 1'b1;
            end
         end
         if (!busy) begin
            chk("c_out", int'(c_out), int'(exp_c));
            chk("irq", int'(irq), int'(exp_irq));
            chk("err", int'(err), int'(exp_err));
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached checks=%0d errors=%0d", n_checks, n_errors);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] rp, re, rm;
      rst = 1'b1; start = 1'b0; stop = 1'b0;
      p_in = 8'd0; e_in = 8'd0; m_in = 8'd0; const_in = 8'd0;
      exp_c = 8'd0; exp_m = 8'd0; exp_irq = 1'b0; exp_err = 1'b0;
      pend_err = 1'b0; pend_c = 8'd0; hold_valid = 1'b0; hold_a = 8'd0; hold_b = 8'd0;
      repeat (3) @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_irq", int'(irq), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_c_out", int'(c_out), 0);
      chk("rst_mm_start", int'(mm_start), 0);
      chk("rst_mm_a", int'(mm_a), 0);
      chk("rst_mm_b", int'(mm_b), 0);
      chk("rst_mm_m", int'(mm_m), 0);
      rst = 1'b0;

      // Pin the reference model to hand-computed values.
      chk("model_pow_5_3_13", pow_mod(5, 3, 13), 8);
      chk("model_pow_2_255_251", pow_mod(2, 255, 251), 32);
      chk("model_mont_r2", int'(mont(8'd1, 8'd3, 8'd13)), 9);

      // 1: basic operation
      base_mm = n_mm; base_done = n_done;
      launch(8'd5, 8'd3, 8'd13, 8'd3, 1'b0);
      wait_done(600, "t1", cyc_wait);
      chk("t1_c_out", int'(c_out), 8);
      chk("t1_err", int'(err), 0);
      chk("t1_irq", int'(irq), 1);
      chk("t1_mm_count", n_mm - base_mm, 13);
      chk("t1_done_count", n_done - base_done, 1);

      // 2: zero exponent
      base_mm = n_mm;
      launch(8'd7, 8'd0, 8'd13, 8'd3, 1'b0);
      wait_done(200, "t2", cyc_wait);
      chk("t2_c_out", int'(c_out), 1);
      chk("t2_mm_count", n_mm - base_mm, 3);

      // 3: even modulus
      base_mm = n_mm;
      launch(8'd5, 8'd3, 8'd12, 8'd3, 1'b0);
      wait_done(20, "t3", cyc_wait);
      chk("t3_done_latency_le2", int'(cyc_wait <= 2), 1);
      chk("t3_err", int'(err), 1);
      chk("t3_c_out_kept", int'(c_out), 1);
      chk("t3_mm_count", n_mm - base_mm, 0);

      // 4: stop during the 5th WAIT
      base_mm = n_mm; base_done = n_done;
      launch(8'd5, 8'd3, 8'd13, 8'd3, 1'b0);
      cyc_wait = 0;
      while (n_mm - base_mm < 5 && cyc_wait < 300) begin
         @(posedge clk);
         cyc_wait++;
      end
      chk("t4_reached_5th_op", n_mm - base_mm, 5);
      repeat (3) @(negedge clk);
      stop = 1'b1;
      @(posedge clk);
      #1;
      exp_irq = 1'b0;
      exp_err = 1'b0;
      chk("t4_busy_after_stop", int'(busy), 0);
      @(negedge clk);
      stop = 1'b0;
      q_a.delete(); q_b.delete();
      repeat (20) @(negedge clk);
      chk("t4_no_done", n_done - base_done, 0);
      chk("t4_mm_count", n_mm - base_mm, 5);
      chk("t4_c_out_kept", int'(c_out), 1);
      chk("t4_busy_idle", int'(busy), 0);

      // 5a: start held through completion
      base_mm = n_mm; base_done = n_done;
      launch(8'd5, 8'd3, 8'd13, 8'd3, 1'b1);
      wait_done(600, "t5a", cyc_wait);
      repeat (30) @(negedge clk);
      chk("t5a_mm_count", n_mm - base_mm, 13);
      chk("t5a_done_count", n_done - base_done, 1);
      chk("t5a_busy", int'(busy), 0);
      start = 1'b0;

      // 5b: second start edge while busy
      base_mm = n_mm; base_done = n_done;
      launch(8'd5, 8'd3, 8'd13, 8'd3, 1'b0);
      repeat (40) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(600, "t5b", cyc_wait);
      repeat (30) @(negedge clk);
      chk("t5b_mm_count", n_mm - base_mm, 13);
      chk("t5b_done_count", n_done - base_done, 1);
      chk("t5b_c_out", int'(c_out), 8);

      // start edge together with stop: no launch, idle stop leaves irq alone
      base_mm = n_mm;
      start = 1'b1; stop = 1'b1;
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      repeat (5) @(negedge clk);
      chk("startstop_busy", int'(busy), 0);
      chk("startstop_mm_count", n_mm - base_mm, 0);
      chk("startstop_irq", int'(irq), 1);

      // 6: full-width exponent, then reset mid-run
      base_mm = n_mm;
      launch(8'd2, 8'hFF, 8'd251, 8'd25, 1'b0);
      wait_done(800, "t6", cyc_wait);
      chk("t6_c_out", int'(c_out), 32);
      chk("t6_mm_count", n_mm - base_mm, 19);
      launch(8'd2, 8'hFF, 8'd251, 8'd25, 1'b0);
      repeat (50) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("t6rst_busy", int'(busy), 0);
      chk("t6rst_done", int'(done), 0);
      chk("t6rst_irq", int'(irq), 0);
      chk("t6rst_err", int'(err), 0);
      chk("t6rst_c_out", int'(c_out), 0);
      chk("t6rst_mm_start", int'(mm_start), 0);
      chk("t6rst_mm_a", int'(mm_a), 0);
      chk("t6rst_mm_b", int'(mm_b), 0);
      chk("t6rst_mm_m", int'(mm_m), 0);
      exp_c = 8'd0; exp_irq = 1'b0; exp_err = 1'b0;
      q_a.delete(); q_b.delete();
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Randomized operations, some with an even modulus
      for (int it = 0; it < 10; it++) begin
         rm = 8'($urandom_range(3, 255)) | 8'd1;
         if ($urandom_range(0, 3) == 0) rm = rm & 8'hFE;
         rp = 8'($urandom_range(0, 255));
         re = 8'($urandom_range(0, 255));
         base_mm = n_mm;
         launch(rp, re, rm, 8'(65536 % int'(rm)), 1'b0);
         wait_done(800, "rand", cyc_wait);
         chk("rand_err", int'(err), int'(!rm[0]));
         chk("rand_c_out", int'(c_out), int'(exp_c));
         if (!rm[0])
            chk("rand_mm_count", n_mm - base_mm, 0);
         else if (re == 8'd0)
            chk("rand_mm_count", n_mm - base_mm, 3);
         else
            chk("rand_mm_count", n_mm - base_mm, 11 + $countones(re));
         repeat (2) @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
